johnson_phase_tracker: RTL
==========================

JOHNSON_PHASE_TRACKER -- requirements
Module: johnson_phase_tracker

Interface
REQ-001 Parameter LOCK_N, default 2: consecutive correct successor transitions needed to declare lock (legal range 1..15).
REQ-002 Parameter ALLOW_HOLD, default 0: 1 = a repeated code is accepted as a stall, not an error.
REQ-003 Parameter REV_W, default 8: width of the revolution counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  sample strobe; d is evaluated only in cycles where en=1.
REQ-007 d  input  4  Johnson code from the upstream 4-bit Johnson counter.
REQ-008 phase  output  3  decoded phase index of the last legal sample.
REQ-009 phase_valid  output  1  high when phase holds a decoded legal code.
REQ-010 locked  output  1  high in state LOCKED.
REQ-011 err_illegal  output  1  one-cycle pulse on an illegal code.
REQ-012 err_skip  output  1  one-cycle pulse on a legal but out-of-sequence code.
REQ-013 rev_tick  output  1  one-cycle pulse on each completed revolution.
REQ-014 rev_count  output  REV_W  completed revolutions, wrapping modulo 2^REV_W.
REQ-015 err_count  output  8  total errors (illegal + skip), saturating at 255.

Function
REQ-016 Legal codes and phases: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7 (upstream update d <= {d[2:0], ~d[3]}); the other 8 codes are illegal.
REQ-017 All outputs are registered; response to a sample taken at edge N appears after edge N+1 (latency 1 cycle).
REQ-018 en=0: no state, output or counter change; pulses deassert.
REQ-019 FSM states UNLOCKED, ACQUIRE, LOCKED; reset state UNLOCKED.
REQ-020 UNLOCKED: legal sample -> ACQUIRE; phase loaded, phase_valid=1, good-transition count cleared; illegal sample -> stay, err_illegal pulse.
REQ-021 ACQUIRE: sample equal to (phase+1) mod 8 increments good count and updates phase; on the LOCK_N-th consecutive good transition -> LOCKED.
REQ-022 Stall (sample equal to phase): with ALLOW_HOLD=1, no change; with ALLOW_HOLD=0, treated as skip.
REQ-023 Skip in ACQUIRE or LOCKED: err_skip pulse, phase reloaded from sample, good count cleared, next state ACQUIRE.
REQ-024 Illegal in any state: err_illegal pulse, phase_valid=0, good count cleared, next state UNLOCKED; phase retains its last value.
REQ-025 rev_tick/rev_count: only in LOCKED, on a good 7 -> 0 transition; the transition that achieves lock never counts.
REQ-026 err_count increments by 1 per err_illegal or err_skip pulse (never both in one cycle) and holds at 255.
REQ-027 err_illegal, err_skip and rev_tick are mutually exclusive in any cycle.

Reset
REQ-028 rst=1 at a clock edge forces UNLOCKED, phase=0, phase_valid=0, locked=0, all pulses 0, rev_count=0, err_count=0, good count 0; it overrides en and d.
REQ-029 Reset asserted mid-lock discards all history; the first legal sample after release behaves as in REQ-020.

Structure
REQ-030 A shared package holds the FSM state encoding, the 8-entry code-to-phase table and the legal-code predicate.
REQ-031 One sub-module, johnson_decode (combinational: d -> phase, legal), is instantiated once.

Verification
REQ-032 Reset, then en=1 with d stepping 0000,0001,0011,0111 -> phase 0,1,2,3; locked rises after the sample 0011 (LOCK_N=2), no errors.
REQ-033 Locked, run 8 more steps through 1000 -> 0000 -> rev_tick single pulse, rev_count=1.
REQ-034 Locked at phase 2, inject d=0101 -> err_illegal pulse, phase_valid=0, locked=0, err_count+1; resume legal sequence -> relock after 2 good transitions.
REQ-035 Locked at phase 3, inject d=1110 (phase 5) -> err_skip pulse, state ACQUIRE, phase=5; with ALLOW_HOLD=0, repeat 1110 -> second err_skip.
REQ-036 en toggled 1/0 every cycle during a legal sequence -> results identical to the dense sequence; rst pulse while locked -> all outputs zero next cycle.
REQ-037 Force 300 illegal samples -> err_count saturates at 255; rev_count wraps 255 -> 0 after 256 revolutions.

Source files
------------

// File: rtl/johnson_phase_tracker_pkg.sv
// Shared definitions for the Johnson phase tracker: FSM encoding, the
// phase-to-code table of a 4-bit Johnson counter and helpers built on it.
package johnson_phase_tracker_pkg;

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2
    } state_e;

    localparam int NumPhases = 8;

    // Entry i is the code the upstream counter emits in phase i.
    localparam logic [7:0][3:0] PhaseCodes = {
        4'b1000, 4'b1100, 4'b1110, 4'b1111,
        4'b0111, 4'b0011, 4'b0001, 4'b0000
    };

    // True when code is one of the eight states a Johnson counter can reach.
    function automatic logic is_legal(input logic [3:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumPhases; i++) begin
            if (code == PhaseCodes[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Phase index of a legal code; illegal codes map to 0 and must be
    // qualified with is_legal by the caller.
    function automatic logic [2:0] code_to_phase(input logic [3:0] code);
        logic [2:0] ph;
        ph = 3'd0;
        for (int i = 0; i < NumPhases; i++) begin
            if (code == PhaseCodes[i]) begin
                ph = 3'(i);
            end
        end
        return ph;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decoder: 4-bit Johnson code to phase index plus legality flag.
module johnson_decode
    import johnson_phase_tracker_pkg::*;
(
    input  logic [3:0] d,
    output logic [2:0] phase,
    output logic       legal
);

    // Table lookup; phase is meaningless when legal is low.
    always_comb begin
        phase = code_to_phase(d);
        legal = is_legal(d);
    end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Tracks the phase of an upstream 4-bit Johnson counter, declares lock after
// LOCK_N consecutive correct successor transitions, flags illegal and
// out-of-sequence codes and counts completed revolutions while locked.
// Samples are registered first, then evaluated, so a sample captured at one
// edge is reflected on the outputs after the following edge.
module johnson_phase_tracker
    import johnson_phase_tracker_pkg::*;
#(
    parameter int unsigned LOCK_N     = 2,
    parameter bit          ALLOW_HOLD = 1'b0,
    parameter int unsigned REV_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       d,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             err_illegal,
    output logic             err_skip,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_count,
    output logic [7:0]       err_count
);

    localparam logic [REV_W-1:0] RevOne  = {{(REV_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LockCnt = LOCK_N[3:0];

    // Sample stage
    logic       samp_en_q;
    logic [3:0] samp_d_q;

    // Tracker state
    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic             pv_q, pv_d;
    logic [3:0]       good_q, good_d;
    logic             ill_q, ill_d;
    logic             skip_q, skip_d;
    logic             tick_q, tick_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [7:0]       errc_q, errc_d;

    logic [2:0] dec_phase;
    logic       dec_legal;
    logic [2:0] succ;
    logic [3:0] good_inc;

    johnson_decode u_decode (
        .d     (samp_d_q),
        .phase (dec_phase),
        .legal (dec_legal)
    );

    // Next-state: classify the registered sample against the tracked phase.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        pv_d     = pv_q;
        good_d   = good_q;
        ill_d    = 1'b0;
        skip_d   = 1'b0;
        tick_d   = 1'b0;
        rev_d    = rev_q;
        errc_d   = errc_q;
        succ     = phase_q + 3'd1;
        good_inc = good_q + 4'd1;

        if (samp_en_q) begin
            if (!dec_legal) begin
                // Phase keeps its last value but is no longer trustworthy.
                ill_d   = 1'b1;
                pv_d    = 1'b0;
                good_d  = 4'd0;
                state_d = StUnlocked;
            end else if (state_q == StUnlocked) begin
                state_d = StAcquire;
                phase_d = dec_phase;
                pv_d    = 1'b1;
                good_d  = 4'd0;
            end else if (ALLOW_HOLD && (dec_phase == phase_q)) begin
                // Upstream stalled: accepted, nothing changes.
                state_d = state_q;
            end else if (dec_phase == succ) begin
                phase_d = dec_phase;
                if (state_q == StLocked) begin
                    // Only a wrap seen while already locked completes a revolution.
                    if (phase_q == 3'd7) begin
                        tick_d = 1'b1;
                        rev_d  = rev_q + RevOne;
                    end
                end else begin
                    good_d = good_inc;
                    if (good_inc == LockCnt) begin
                        state_d = StLocked;
                    end
                end
            end else begin
                // Legal but out of order (including a stall when holds are not allowed).
                skip_d  = 1'b1;
                phase_d = dec_phase;
                good_d  = 4'd0;
                state_d = StAcquire;
            end
        end

        if ((ill_d || skip_d) && (errc_q != 8'hFF)) begin
            errc_d = errc_q + 8'd1;
        end
    end

    // State and sample registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_en_q <= 1'b0;
            samp_d_q  <= 4'd0;
            state_q   <= StUnlocked;
            phase_q   <= 3'd0;
            pv_q      <= 1'b0;
            good_q    <= 4'd0;
            ill_q     <= 1'b0;
            skip_q    <= 1'b0;
            tick_q    <= 1'b0;
            rev_q     <= '0;
            errc_q    <= 8'd0;
        end else begin
            samp_en_q <= en;
            samp_d_q  <= d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            pv_q      <= pv_d;
            good_q    <= good_d;
            ill_q     <= ill_d;
            skip_q    <= skip_d;
            tick_q    <= tick_d;
            rev_q     <= rev_d;
            errc_q    <= errc_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        phase       = phase_q;
        phase_valid = pv_q;
        locked      = (state_q == StLocked);
        err_illegal = ill_q;
        err_skip    = skip_q;
        rev_tick    = tick_q;
        rev_count   = rev_q;
        err_count   = errc_q;
    end

endmodule
